// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader.
// The CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: first byte lands in [7:0].
// word_full flags the push that completes a word.
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [7:0]       din,
    output logic [WIDTH-1:0] word,
    output logic             word_full
);
    logic [1:0] cnt;

    assign word_full = push && (cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            word <= '0;
        end else if (flush) begin
            cnt  <= '0;
            word <= '0;
        end else if (push) begin
            word[{cnt, 3'b000} +: 8] <= din;
            cnt                      <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream into instruction memory, then CPU release.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             cpu_run,
    output logic             err
);
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int LW        = LEN_BYTES * 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t               state, nxt;
    logic [ADDR_BITS:0]   word_idx;
    logic [LW-1:0]        len, len_in;
    logic                 hs, go, push, word_full, last_word;
    logic                 rdy_nxt, busy_nxt;

    assign hs        = rx_valid && rx_ready;
    assign go        = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign push      = hs && (state == S_DATA);
    assign len_in    = {rx_data, len[7:0]};
    assign last_word = (LW'(word_idx) + LW'(1)) == len;
    assign mem_addr  = WIDTH'({word_idx, 2'b00});

    imem_word_packer #(.WIDTH(WIDTH)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (go),
        .push      (push),
        .din       (rx_data),
        .word      (mem_wdata),
        .word_full (word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_t csum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    csum <= '0;
        else if (go)   csum <= '0;
        else if (push) csum <= csum ^ rx_data;
    end
`endif

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (go) nxt = S_LEN_LO;
            S_LEN_LO: if (hs) nxt = S_LEN_HI;
            S_LEN_HI: if (hs) begin
                if (len_in == '0)             nxt = S_FIN;
                else if (32'(len_in) > DEPTH) nxt = S_ERR;
                else                          nxt = S_DATA;
            end
            S_DATA:   if (word_full) nxt = S_WRITE;
            S_WRITE:  nxt = last_word ? S_FIN : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:    if (hs) nxt = (rx_data == csum) ? S_DONE : S_ERR;
`endif
            S_DONE,
            S_ERR:    if (go) nxt = S_LEN_LO;
            default:  nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        rdy_nxt  = (nxt == S_LEN_LO) || (nxt == S_LEN_HI) || (nxt == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        rdy_nxt  = rdy_nxt || (nxt == S_CHK);
`endif
        busy_nxt = !((nxt == S_IDLE) || (nxt == S_DONE) || (nxt == S_ERR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rx_ready <= 1'b0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cpu_run  <= 1'b0;
            err      <= 1'b0;
            word_idx <= '0;
            len      <= '0;
        end else begin
            state    <= nxt;
            rx_ready <= rdy_nxt;
            mem_we   <= (nxt == S_WRITE);
            busy     <= busy_nxt;
            done     <= (nxt == S_DONE);
            cpu_run  <= (nxt == S_DONE);
            err      <= (nxt == S_ERR);
            if (go) begin
                word_idx <= '0;
                len      <= '0;
            end
            if (state == S_LEN_LO && hs) len[7:0] <= rx_data;
            if (state == S_LEN_HI && hs) len      <= len_in;
            if (state == S_WRITE)        word_idx <= word_idx + 1'b1;
        end
    end
endmodule
